fpu_forward_unit: RTL and testbench

- Parametrised successor to the FPU forwarding comparator.
- Tracks in-flight FPU destination writes in an internal DEPTH-stage shadow pipeline, each entry tagged with its result latency.
- For every source operand at decode, selects the youngest matching in-flight producer (one-hot bypass select).
- Raises a stall when that youngest producer's result is not yet available.
- Sits between the FPU decode stage and the FPU execute pipeline; drives the bypass muxes and the decode stall.

---
 rtl/fpu_pkg.sv | 20 ++
 rtl/fpu_fwd_src_match.sv | 44 ++++
 rtl/fpu_forward_unit.sv | 80 ++++++++
 tb/tb_fpu_forward_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU forwarding definitions: register/latency widths, default depth and
// the layout of one in-flight entry, reused by issue and writeback logic.
package fpu_pkg;
  localparam int FPU_REG_W = 5;
  localparam int FPU_DEPTH = 4;
  localparam int FPU_LAT_W = 3;

  typedef struct packed {
    logic                 v;
    logic [FPU_REG_W-1:0] rd;
    logic [FPU_LAT_W-1:0] lat;
  } fpu_fwd_entry_t;

  // Issue latency is forced into 1..depth so every entry eventually becomes ready.
  function automatic int fpu_clamp_lat(int lat, int depth);
    if (lat < 1)     return 1;
    if (lat > depth) return depth;
    return lat;
  endfunction
endpackage

// File: rtl/fpu_fwd_src_match.sv
// Per-source comparator: matches one operand against every in-flight entry and
// picks the youngest producer, reporting select, hit and stall.
module fpu_fwd_src_match
  import fpu_pkg::*;
#(
  parameter int DEPTH = FPU_DEPTH,
  parameter int REG_W = FPU_REG_W,
  parameter int LAT_W = FPU_LAT_W
) (
  input  logic                         src_valid,
  input  logic [REG_W-1:0]             src_rs,
  input  logic [DEPTH-1:0]             ent_v,
  input  logic [DEPTH-1:0][REG_W-1:0]  ent_rd,
  input  logic [DEPTH-1:0][LAT_W-1:0]  ent_lat,
  output logic [DEPTH-1:0]             sel,
  output logic                         hit,
  output logic                         stall
);
  logic [DEPTH-1:0] match;
  logic [DEPTH-1:0] rdy;
  logic             found;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = src_valid & ent_v[i] & (ent_rd[i] == src_rs);
      rdy[i]   = ((i + 1) >= int'(ent_lat[i]));
    end
  end

  // Stage 0 is youngest, so the first match scanning upward wins.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (match[i] && !found) begin
        sel[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  assign hit   = |(sel & rdy);
  assign stall = |(sel & ~rdy);
endmodule

// File: rtl/fpu_forward_unit.sv
// FPU forwarding unit: shadow pipeline of in-flight destination writes plus
// per-source youngest-producer bypass selection and decode stall.
module fpu_forward_unit
  import fpu_pkg::*;
#(
  parameter int DEPTH = FPU_DEPTH,
  parameter int NSRC  = 2,
  parameter int REG_W = FPU_REG_W,
  parameter int LAT_W = FPU_LAT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    adv,
  input  logic                    flush,
  input  logic                    issue_valid,
  input  logic                    issue_wen,
  input  logic [REG_W-1:0]        issue_rd,
  input  logic [LAT_W-1:0]        issue_lat,
  input  logic [NSRC-1:0]         src_valid,
  input  logic [NSRC*REG_W-1:0]   src_rs,
  output logic [NSRC*DEPTH-1:0]   fwd_sel,
  output logic [NSRC-1:0]         fwd_hit,
  output logic                    stall,
  output logic                    busy
);
  logic [DEPTH-1:0]            v_q, v_d;
  logic [DEPTH-1:0][REG_W-1:0] rd_q, rd_d;
  logic [DEPTH-1:0][LAT_W-1:0] lat_q, lat_d;
  logic [LAT_W-1:0]            lat_in;
  logic [NSRC-1:0]             src_stall;

  assign lat_in = LAT_W'(fpu_clamp_lat(int'(issue_lat), DEPTH));

  // A stalled issue becomes a bubble so the held op is not entered twice.
  always_comb begin
    v_d   = v_q;
    rd_d  = rd_q;
    lat_d = lat_q;
    if (adv) begin
      for (int i = 1; i < DEPTH; i++) begin
        v_d[i]   = v_q[i-1];
        rd_d[i]  = rd_q[i-1];
        lat_d[i] = lat_q[i-1];
      end
      v_d[0]   = issue_valid & issue_wen & ~stall;
      rd_d[0]  = issue_rd;
      lat_d[0] = lat_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) v_q <= '0;
    else              v_q <= v_d;
    rd_q  <= rd_d;
    lat_q <= lat_d;
  end

  genvar j;
  generate
    for (j = 0; j < NSRC; j++) begin : g_src
      fpu_fwd_src_match #(
        .DEPTH (DEPTH),
        .REG_W (REG_W),
        .LAT_W (LAT_W)
      ) u_match (
        .src_valid (src_valid[j]),
        .src_rs    (src_rs[j*REG_W +: REG_W]),
        .ent_v     (v_q),
        .ent_rd    (rd_q),
        .ent_lat   (lat_q),
        .sel       (fwd_sel[j*DEPTH +: DEPTH]),
        .hit       (fwd_hit[j]),
        .stall     (src_stall[j])
      );
    end
  endgenerate

  assign stall = |src_stall;
  assign busy  = |v_q;
endmodule

// File: tb/tb_fpu_forward_unit.sv
// Bench for fpu_forward_unit: directed vector table followed by random traffic
// checked against an age-based list model of in-flight ops.
module tb_fpu_forward_unit;
  localparam int DEPTH = 4;

  logic       clk, rst, adv, flush, issue_valid, issue_wen;
  logic [4:0] issue_rd;
  logic [2:0] issue_lat;
  logic [1:0] src_valid;
  logic [9:0] src_rs;
  logic [7:0] fwd_sel;
  logic [1:0] fwd_hit;
  logic       stall, busy;

  int checks = 0;
  int failures = 0;

  fpu_forward_unit dut (
    .clk(clk), .rst(rst), .adv(adv), .flush(flush),
    .issue_valid(issue_valid), .issue_wen(issue_wen),
    .issue_rd(issue_rd), .issue_lat(issue_lat),
    .src_valid(src_valid), .src_rs(src_rs),
    .fwd_sel(fwd_sel), .fwd_hit(fwd_hit), .stall(stall), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst, adv, flush, iv;
    logic [4:0] rd;
    logic [2:0] lat;
    logic [1:0] sv;
    logic [4:0] rs0, rs1;
    logic [7:0] esel;
    logic [1:0] ehit;
    logic       estall, ebusy;
  } vec_t;

  typedef struct {
    int rd;
    int lat;
    int age;
  } op_t;

  op_t mq[$];

  function automatic vec_t mk(logic r, logic a, logic f, logic iv, logic [4:0] rd,
                              logic [2:0] lat, logic [1:0] sv, logic [4:0] rs0,
                              logic [4:0] rs1, logic [7:0] esel, logic [1:0] ehit,
                              logic est, logic ebz);
    vec_t x;
    x.rst = r; x.adv = a; x.flush = f; x.iv = iv; x.rd = rd; x.lat = lat;
    x.sv = sv; x.rs0 = rs0; x.rs1 = rs1; x.esel = esel; x.ehit = ehit;
    x.estall = est; x.ebusy = ebz;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic a, input logic f, input logic iv,
                       input logic iw, input logic [4:0] rd, input logic [2:0] lat,
                       input logic [1:0] sv, input logic [4:0] rs0, input logic [4:0] rs1);
    rst = r; adv = a; flush = f; issue_valid = iv; issue_wen = iw;
    issue_rd = rd; issue_lat = lat; src_valid = sv; src_rs = {rs1, rs0};
  endtask

  // Youngest op (smallest age) writing the source register is the producer.
  task automatic model_eval(input logic [1:0] sv, input logic [4:0] rs0, input logic [4:0] rs1,
                            output logic [7:0] sel, output logic [1:0] hit,
                            output logic st, output logic bz);
    sel = '0; hit = '0; st = 1'b0;
    bz = (mq.size() != 0);
    for (int j = 0; j < 2; j++) begin
      int best, blat, rs;
      best = -1; blat = 0;
      rs = (j == 0) ? int'(rs0) : int'(rs1);
      foreach (mq[k])
        if (mq[k].rd == rs && (best < 0 || mq[k].age < best)) begin
          best = mq[k].age; blat = mq[k].lat;
        end
      if (sv[j] && best >= 0) begin
        sel[j*DEPTH + best] = 1'b1;
        if (best + 1 >= blat) hit[j] = 1'b1;
        else                  st = 1'b1;
      end
    end
  endtask

  task automatic model_step(input logic r, input logic a, input logic f, input logic iv,
                            input logic iw, input logic [4:0] rd, input logic [2:0] lat,
                            input logic st);
    op_t nq[$];
    int  l;
    if (r || f) begin
      mq.delete();
    end else if (a) begin
      foreach (mq[k]) if (mq[k].age + 1 < DEPTH) nq.push_back('{mq[k].rd, mq[k].lat, mq[k].age + 1});
      if (iv && iw && !st) begin
        l = int'(lat);
        if (l < 1) l = 1;
        if (l > DEPTH) l = DEPTH;
        nq.push_back('{int'(rd), l, 0});
      end
      mq = nq;
    end
  endtask

  vec_t tv[$];

  initial begin
    logic [7:0] msel;
    logic [1:0] mhit;
    logic       mst, mbz;
    logic       r, a, f, iv, iw;
    logic [4:0] rd, rs0, rs1;
    logic [2:0] lat;
    logic [1:0] sv;

    // reset / ready forward / latency stall with bubbles
    tv.push_back(mk(0,1,0,0, 0,0,2'b11, 3, 3,8'h00,2'b00,0,0));
    tv.push_back(mk(0,1,0,1, 7,1,2'b00, 0, 0,8'h00,2'b00,0,0));
    tv.push_back(mk(0,1,0,0, 0,0,2'b01, 7, 0,8'h01,2'b01,0,1));
    tv.push_back(mk(0,1,1,0, 0,0,2'b00, 0, 0,8'h00,2'b00,0,1));
    tv.push_back(mk(0,1,0,1, 9,3,2'b00, 0, 0,8'h00,2'b00,0,0));
    tv.push_back(mk(0,1,0,1,20,1,2'b10, 0, 9,8'h10,2'b00,1,1));
    tv.push_back(mk(0,1,0,1,21,1,2'b10, 0, 9,8'h20,2'b00,1,1));
    tv.push_back(mk(0,1,0,0, 0,0,2'b10, 0, 9,8'h40,2'b10,0,1));
    // flush with issue, then youngest wins
    tv.push_back(mk(0,1,1,1, 9,1,2'b11,20,21,8'h00,2'b00,0,1));
    tv.push_back(mk(0,1,0,1, 5,1,2'b01, 9, 0,8'h00,2'b00,0,0));
    tv.push_back(mk(0,1,0,1, 5,2,2'b00, 0, 0,8'h00,2'b00,0,1));
    tv.push_back(mk(0,1,0,0, 0,0,2'b01, 5, 0,8'h01,2'b00,1,1));
    tv.push_back(mk(0,1,0,0, 0,0,2'b01, 5, 0,8'h02,2'b01,0,1));
    // hold with ignored issues, then advance to retirement
    for (int k = 0; k < 3; k++) tv.push_back(mk(0,0,0,1,5,1,2'b01,5,0,8'h04,2'b01,0,1));
    tv.push_back(mk(0,1,0,0, 0,0,2'b01, 5, 0,8'h04,2'b01,0,1));
    tv.push_back(mk(0,1,0,0, 0,0,2'b01, 5, 0,8'h08,2'b01,0,1));
    // lat=0 behaves as 1: walk every stage then retire
    tv.push_back(mk(0,1,0,1,11,0,2'b01,11, 0,8'h00,2'b00,0,0));
    tv.push_back(mk(0,1,0,0, 0,0,2'b01,11, 0,8'h01,2'b01,0,1));
    tv.push_back(mk(0,1,0,0, 0,0,2'b01,11, 0,8'h02,2'b01,0,1));
    tv.push_back(mk(0,1,0,0, 0,0,2'b01,11, 0,8'h04,2'b01,0,1));
    tv.push_back(mk(0,1,0,0, 0,0,2'b01,11, 0,8'h08,2'b01,0,1));
    tv.push_back(mk(0,1,0,0, 0,0,2'b01,11, 0,8'h00,2'b00,0,0));
    // lat=7 behaves as DEPTH
    tv.push_back(mk(0,1,0,1,12,7,2'b10, 0,12,8'h00,2'b00,0,0));
    tv.push_back(mk(0,1,0,0, 0,0,2'b10, 0,12,8'h10,2'b00,1,1));
    tv.push_back(mk(0,1,0,0, 0,0,2'b10, 0,12,8'h20,2'b00,1,1));
    tv.push_back(mk(0,1,0,0, 0,0,2'b10, 0,12,8'h40,2'b00,1,1));
    tv.push_back(mk(0,1,0,0, 0,0,2'b10, 0,12,8'h80,2'b10,0,1));
    tv.push_back(mk(0,1,0,0, 0,0,2'b10, 0,12,8'h00,2'b00,0,0));
    // equal sources, register 0, reset mid-stall
    tv.push_back(mk(0,1,0,1, 3,2,2'b00, 0, 0,8'h00,2'b00,0,0));
    tv.push_back(mk(0,1,0,0, 0,0,2'b11, 3, 3,8'h11,2'b00,1,1));
    tv.push_back(mk(0,1,0,1, 0,1,2'b00, 0, 0,8'h00,2'b00,0,1));
    tv.push_back(mk(0,1,0,0, 0,0,2'b11, 0, 3,8'h41,2'b11,0,1));
    tv.push_back(mk(0,1,0,1, 6,4,2'b00, 0, 0,8'h00,2'b00,0,1));
    tv.push_back(mk(0,1,0,0, 0,0,2'b01, 6, 0,8'h01,2'b00,1,1));
    tv.push_back(mk(1,1,0,0, 0,0,2'b01, 6, 0,8'h02,2'b00,1,1));
    tv.push_back(mk(0,1,0,0, 0,0,2'b01, 6, 0,8'h00,2'b00,0,0));

    drive(1,0,0,0,0,0,0,0,0,0);
    repeat (2) @(posedge clk);
    #1;

    foreach (tv[n]) begin
      drive(tv[n].rst, tv[n].adv, tv[n].flush, tv[n].iv, tv[n].iv, tv[n].rd,
            tv[n].lat, tv[n].sv, tv[n].rs0, tv[n].rs1);
      #1;
      chk($sformatf("vec%0d fwd_sel", n), 32'(fwd_sel), 32'(tv[n].esel));
      chk($sformatf("vec%0d fwd_hit", n), 32'(fwd_hit), 32'(tv[n].ehit));
      chk($sformatf("vec%0d stall", n), 32'(stall), 32'(tv[n].estall));
      chk($sformatf("vec%0d busy", n), 32'(busy), 32'(tv[n].ebusy));
      @(posedge clk);
      #1;
    end

    // the directed table ends with an empty pipeline, matching the empty model
    for (int c = 0; c < 3000; c++) begin
      r   = ($urandom % 100) == 0;
      f   = ($urandom % 30) == 0;
      a   = ($urandom % 4) != 0;
      iv  = $urandom % 2;
      iw  = ($urandom % 4) != 0;
      rd  = 5'($urandom % 8);
      lat = 3'($urandom % 6);
      sv  = 2'($urandom % 4);
      rs0 = 5'($urandom % 8);
      rs1 = 5'($urandom % 8);
      drive(r, a, f, iv, iw, rd, lat, sv, rs0, rs1);
      #1;
      model_eval(sv, rs0, rs1, msel, mhit, mst, mbz);
      chk($sformatf("rnd%0d fwd_sel", c), 32'(fwd_sel), 32'(msel));
      chk($sformatf("rnd%0d fwd_hit", c), 32'(fwd_hit), 32'(mhit));
      chk($sformatf("rnd%0d stall", c), 32'(stall), 32'(mst));
      chk($sformatf("rnd%0d busy", c), 32'(busy), 32'(mbz));
      @(posedge clk);
      model_step(r, a, f, iv, iw, rd, lat, mst);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
